// File: rtl/title_sequencer.sv
// Title-screen sequencer: scrolls the banner in, holds it, blinks the
// "press start" prompt, and on a debounced press scrolls the banner out
// and pulses game_start. Re-arms on game_over.
module title_sequencer #(
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned TARGET_X        = 160,
    parameter int unsigned TARGET_Y        = 100,
    parameter int unsigned SCROLL_STEP     = 4,
    parameter int unsigned HOLD_FRAMES     = 60,
    parameter int unsigned BLINK_HALF      = 30,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       game_over,
    output logic [9:0] origin_x,
    output logic [9:0] origin_y,
    output logic       banner_en,
    output logic       prompt_en,
    output logic       game_start,
    output logic       in_title,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_SCROLL = 3'd0,
        ST_HOLD   = 3'd1,
        ST_PROMPT = 3'd2,
        ST_EXIT   = 3'd3,
        ST_GAME   = 3'd4
    } state_e;

    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [9:0]         SCREEN_Y  = 10'(SCREEN_H);
    localparam logic [9:0]         TGT_X     = 10'(TARGET_X);
    localparam logic [9:0]         TGT_Y     = 10'(TARGET_Y);
    localparam logic [9:0]         STEP      = 10'(SCROLL_STEP);
    localparam logic [9:0]         SNAP_Y    = 10'(TARGET_Y + SCROLL_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEBOUNCE_FRAMES);

    state_e             state_q, state_d;
    logic [9:0]         y_q, y_d;
    logic               banner_q, banner_d;
    logic               prompt_q, prompt_d;
    logic               gs_q, gs_d;
    logic               in_title_q, in_title_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [DEB_W-1:0]   high_q, high_d;
    logic               armed_q, armed_d;
    logic               sync1_q, sync2_q;
    logic               press;

    // Two-flop synchronizer for the raw asynchronous button.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= start_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: per-frame sampling, one press per hold, re-armed by a low sample.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        high_d  = high_q;
        armed_d = armed_q;
        press   = 1'b0;
        if (frame_tick) begin
            if (!sync2_q) begin
                armed_d = 1'b1;
                high_d  = '0;
            end else begin
                if (high_q != DEB_MAX) high_d = high_q + 1'b1;
                if (armed_q && high_d == DEB_MAX) begin
                    press   = 1'b1;
                    armed_d = 1'b0;
                end
            end
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        banner_d   = banner_q;
        prompt_d   = prompt_q;
        gs_d       = 1'b0;
        in_title_d = in_title_q;
        hold_d     = hold_q;
        blink_d    = blink_q;
        unique case (state_q)
            ST_SCROLL, ST_HOLD: begin
                if (frame_tick) begin
                    if (press) begin
                        // Skip straight to the prompt; this press does not start the game.
                        y_d      = TGT_Y;
                        state_d  = ST_PROMPT;
                        prompt_d = 1'b1;
                        blink_d  = '0;
                    end else if (state_q == ST_SCROLL) begin
                        if (y_q <= SNAP_Y) begin
                            y_d     = TGT_Y;
                            state_d = ST_HOLD;
                            hold_d  = '0;
                        end else begin
                            y_d = y_q - STEP;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                        if (hold_d == HOLD_MAX) begin
                            state_d  = ST_PROMPT;
                            prompt_d = 1'b1;
                            blink_d  = '0;
                        end
                    end
                end
            end
            ST_PROMPT: begin
                if (frame_tick) begin
                    if (press) begin
                        state_d  = ST_EXIT;
                        prompt_d = 1'b0;
                    end else begin
                        blink_d = blink_q + 1'b1;
                        if (blink_d == BLINK_MAX) begin
                            blink_d  = '0;
                            prompt_d = ~prompt_q;
                        end
                    end
                end
            end
            ST_EXIT: begin
                if (frame_tick) begin
                    if (y_q == '0) begin
                        state_d    = ST_GAME;
                        banner_d   = 1'b0;
                        in_title_d = 1'b0;
                        gs_d       = 1'b1;
                    end else begin
                        y_d = (y_q < STEP) ? '0 : y_q - STEP;
                    end
                end
            end
            ST_GAME: begin
                // game_over acts on any cycle, not just frame ticks.
                if (game_over) begin
                    state_d    = ST_SCROLL;
                    y_d        = SCREEN_Y;
                    banner_d   = 1'b1;
                    in_title_d = 1'b1;
                end
            end
            default: state_d = ST_SCROLL;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SCROLL;
            y_q        <= SCREEN_Y;
            banner_q   <= 1'b1;
            prompt_q   <= 1'b0;
            gs_q       <= 1'b0;
            in_title_q <= 1'b1;
            hold_q     <= '0;
            blink_q    <= '0;
            high_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            banner_q   <= banner_d;
            prompt_q   <= prompt_d;
            gs_q       <= gs_d;
            in_title_q <= in_title_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            high_q     <= high_d;
            armed_q    <= armed_d;
        end
    end

    assign origin_x   = TGT_X;
    assign origin_y   = y_q;
    assign banner_en  = banner_q;
    assign prompt_en  = prompt_q;
    assign game_start = gs_q;
    assign in_title   = in_title_q;
    assign state      = state_q;

endmodule

// File: tb/tb_title_sequencer.sv
// Self-checking bench for title_sequencer: scoreboard of expected outputs per
// frame tick, a vector table for the main flow, and hand-written corner cases.
module tb_title_sequencer;

    localparam logic [2:0] S_SCROLL = 3'd0;
    localparam logic [2:0] S_HOLD   = 3'd1;
    localparam logic [2:0] S_PROMPT = 3'd2;
    localparam logic [2:0] S_EXIT   = 3'd3;
    localparam logic [2:0] S_GAME   = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       game_over = 1'b0;
    logic [9:0] origin_x, origin_y;
    logic       banner_en, prompt_en, game_start, in_title;
    logic [2:0] state;

    title_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .game_over  (game_over),
        .origin_x   (origin_x),
        .origin_y   (origin_y),
        .banner_en  (banner_en),
        .prompt_en  (prompt_en),
        .game_start (game_start),
        .in_title   (in_title),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [9:0] y;
        logic       pen;
        logic       ben;
        logic       tit;
    } exp_t;

    typedef struct {
        int   n;
        logic btn;
        exp_t e;
    } vec_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   gs_count = 0;

    // Count game_start pulses (value seen at posedge is the previous cycle's output).
    always @(posedge clk) if (game_start === 1'b1) gs_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [9:0] y,
                                input logic pen, input logic ben, input logic tit);
        exp_t e;
        e.st = st; e.y = y; e.pen = pen; e.ben = ben; e.tit = tit;
        return e;
    endfunction

    function automatic vec_t mkv(input int n, input logic btn, input logic [2:0] st,
                                 input logic [9:0] y, input logic pen, input logic ben,
                                 input logic tit);
        vec_t v;
        v.n = n; v.btn = btn; v.e = mk(st, y, pen, ben, tit);
        return v;
    endfunction

    // Drive the button, let it cross the synchronizer, then issue one frame tick.
    task automatic tick(input logic btn);
        start_btn = btn;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic compare_out(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got empty scoreboard want entry", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " state"}, 32'(state), 32'(e.st));
            check({name, " origin_y"}, 32'(origin_y), 32'(e.y));
            check({name, " prompt_en"}, 32'(prompt_en), 32'(e.pen));
            check({name, " banner_en"}, 32'(banner_en), 32'(e.ben));
            check({name, " in_title"}, 32'(in_title), 32'(e.tit));
            check({name, " origin_x"}, 32'(origin_x), 32'd160);
        end
    endtask

    task automatic tick_expect(input string name, input logic btn, input exp_t e);
        sb_q.push_back(e);
        tick(btn);
        compare_out(name);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        for (int i = 1; i < v.n; i++) tick(v.btn);
        tick_expect(name, v.btn, v.e);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " state"}, 32'(state), 32'(S_SCROLL));
        check({name, " origin_y"}, 32'(origin_y), 32'd480);
        check({name, " origin_x"}, 32'(origin_x), 32'd160);
        check({name, " banner_en"}, 32'(banner_en), 32'd1);
        check({name, " prompt_en"}, 32'(prompt_en), 32'd0);
        check({name, " game_start"}, 32'(game_start), 32'd0);
        check({name, " in_title"}, 32'(in_title), 32'd1);
    endtask

    // Scroll-in from SCREEN_H: 480,476,...,104 then 100 and HOLD on tick 95.
    task automatic scroll_in(input string name, input logic btn);
        for (int k = 1; k <= 95; k++) begin
            logic [9:0] ey;
            logic [2:0] es;
            ey = (k < 95) ? 10'(480 - 4 * k) : 10'd100;
            es = (k < 95) ? S_SCROLL : S_HOLD;
            tick_expect(name, btn, mk(es, ey, 1'b0, 1'b1, 1'b1));
        end
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = mkv(59, 1'b0, S_HOLD,   10'd100, 1'b0, 1'b1, 1'b1);
        tbl[1] = mkv(1,  1'b0, S_PROMPT, 10'd100, 1'b1, 1'b1, 1'b1);
        tbl[2] = mkv(29, 1'b0, S_PROMPT, 10'd100, 1'b1, 1'b1, 1'b1);
        tbl[3] = mkv(1,  1'b0, S_PROMPT, 10'd100, 1'b0, 1'b1, 1'b1);
        tbl[4] = mkv(30, 1'b0, S_PROMPT, 10'd100, 1'b1, 1'b1, 1'b1);
        tbl[5] = mkv(2,  1'b1, S_PROMPT, 10'd100, 1'b1, 1'b1, 1'b1);
        tbl[6] = mkv(1,  1'b1, S_EXIT,   10'd100, 1'b0, 1'b1, 1'b1);
        tbl[7] = mkv(24, 1'b1, S_EXIT,   10'd4,   1'b0, 1'b1, 1'b1);
        tbl[8] = mkv(1,  1'b1, S_EXIT,   10'd0,   1'b0, 1'b1, 1'b1);

        // Reset state.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Normal flow: scroll-in, hold, blink, start press, exit.
        scroll_in("scroll", 1'b0);
        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // 26th exit tick enters GAME with a single-cycle game_start.
        tick_expect("enter game", 1'b1, mk(S_GAME, 10'd0, 1'b0, 1'b0, 1'b0));
        check("game_start high", 32'(game_start), 32'd1);
        @(negedge clk);
        check("game_start one cycle", 32'(game_start), 32'd0);
        tick_expect("game press ignored", 1'b1, mk(S_GAME, 10'd0, 1'b0, 1'b0, 1'b0));

        // game_over mid-frame returns to SCROLL the next cycle.
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        check("game_over state", 32'(state), 32'(S_SCROLL));
        check("game_over origin_y", 32'(origin_y), 32'd480);
        check("game_over banner_en", 32'(banner_en), 32'd1);
        check("game_over in_title", 32'(in_title), 32'd1);
        check("game_start count", 32'(gs_count), 32'd1);

        // Skip: press lands on scroll tick 10 (button high on ticks 8..10).
        for (int k = 1; k <= 9; k++)
            tick_expect("skip scroll", (k >= 8), mk(S_SCROLL, 10'(480 - 4 * k), 1'b0, 1'b1, 1'b1));
        tick_expect("skip press", 1'b1, mk(S_PROMPT, 10'd100, 1'b1, 1'b1, 1'b1));
        for (int k = 0; k < 200; k++) begin
            tick(1'b1);
            check("held no start", 32'(state), 32'(S_PROMPT));
        end

        // game_over outside GAME has no effect.
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        check("prompt game_over state", 32'(state), 32'(S_PROMPT));
        check("prompt game_over origin_y", 32'(origin_y), 32'd100);

        // Release, then press again to start.
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        check("repress 2 ticks", 32'(state), 32'(S_PROMPT));
        tick(1'b1);
        check("repress exit", 32'(state), 32'(S_EXIT));
        check("repress prompt_en", 32'(prompt_en), 32'd0);
        for (int k = 1; k <= 5; k++)
            tick_expect("exit step", 1'b1, mk(S_EXIT, 10'(100 - 4 * k), 1'b0, 1'b1, 1'b1));

        // Asynchronous reset in the middle of EXIT, button held.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid reset");
        repeat (3) @(negedge clk);
        check("no game_start from exit", 32'(gs_count), 32'd1);

        // Button held through reset: ignored until a low sample.
        rst_n = 1'b1;
        @(negedge clk);
        scroll_in("held scroll", 1'b1);
        run_vec("held hold", mkv(60, 1'b1, S_PROMPT, 10'd100, 1'b1, 1'b1, 1'b1));
        for (int k = 0; k < 5; k++) tick(1'b1);
        check("held prompt stays", 32'(state), 32'(S_PROMPT));
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        check("held rearm 2 ticks", 32'(state), 32'(S_PROMPT));
        tick(1'b1);
        check("held rearm exit", 32'(state), 32'(S_EXIT));
        check("final game_start count", 32'(gs_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
